// File: rtl/hc595_chain_drive.sv
// rtl/hc595_chain_drive.sv - serial frame driver for a daisy-chained 74HC595 string
// Shifts a latched frame out at a programmable SCK rate, then pulses RCK; also drives SRCLR and OE.
module hc595_chain_drive #(
  parameter int MAX_BITS = 256,
  parameter int LEN_W    = 9,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAX_BITS-1:0] wr_data,
  input  logic [LEN_W-1:0]    wr_len,
  input  logic                wr_lsb_first,
  input  logic [DIV_W-1:0]    sck_div,
  input  logic                wr_start,
  input  logic                clr_req,
  input  logic                oe_en,
  output logic                wr_ready,
  output logic                wr_done,
  output logic                hc595_ser,
  output logic                hc595_sck,
  output logic                hc595_rck,
  output logic                hc595_srclr_n,
  output logic                hc595_oe_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LATCH,
    S_CLEAR,
    S_CLR_LATCH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                lsb_q, lsb_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W:0]      div_cnt_q, div_cnt_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                oe_n_q, oe_n_d;

  logic [LEN_W-1:0]    len_eff;
  logic                h_end;
  logic [LEN_W-1:0]    bit_k;
  logic [LEN_W-1:0]    bit_idx;
  logic [MAX_BITS-1:0] data_shift;
  logic                cur_bit;

  assign len_eff = (wr_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : wr_len;
  assign h_end   = (div_cnt_q == {1'b0, div_q});

  // In LATCH the bit counter has already moved past the frame, so hold the last shifted bit.
  assign bit_k      = (state_q == S_LATCH) ? (len_q - LEN_W'(1)) : bit_cnt_q;
  assign bit_idx    = lsb_q ? bit_k : (len_q - LEN_W'(1) - bit_k);
  assign data_shift = data_q >> bit_idx;
  assign cur_bit    = data_shift[0];

  assign oe_n_d = ~oe_en;

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    len_d         = len_q;
    lsb_d         = lsb_q;
    div_d         = div_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    wr_ready      = 1'b0;
    wr_done       = 1'b0;
    hc595_ser     = 1'b0;
    hc595_sck     = 1'b0;
    hc595_rck     = 1'b0;
    hc595_srclr_n = 1'b1;

    case (state_q)
      S_IDLE: begin
        wr_ready  = 1'b1;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        if (clr_req || wr_start) begin
          data_d = wr_data;
          len_d  = len_eff;
          lsb_d  = wr_lsb_first;
          div_d  = sck_div;
        end
        if (clr_req) begin
          state_d = S_CLEAR;
        end else if (wr_start) begin
          state_d = (len_eff == '0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        hc595_ser = cur_bit;
        if (h_end) begin
          div_cnt_d = '0;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        hc595_ser = cur_bit;
        hc595_sck = 1'b1;
        if (h_end) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == len_q - LEN_W'(1)) ? S_LATCH : S_SETUP;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        hc595_ser = cur_bit;
        hc595_rck = 1'b1;
        if (h_end) begin
          div_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        hc595_srclr_n = 1'b0;
        if (h_end) begin
          div_cnt_d = '0;
          state_d   = S_CLR_LATCH;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_CLR_LATCH: begin
        hc595_rck = 1'b1;
        if (h_end) begin
          div_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        wr_done = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      len_q     <= '0;
      lsb_q     <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      oe_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      lsb_q     <= lsb_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      oe_n_q    <= oe_n_d;
    end
  end

  assign hc595_oe_n = oe_n_q;

endmodule

// File: tb/tb_hc595_chain_drive.sv
// tb/tb_hc595_chain_drive.sv - self-checking bench for hc595_chain_drive
// Waveforms are predicted per cycle from frame parameters, plus literal pins per scenario.
module tb_hc595_chain_drive;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] wr_data = '0;
  logic [8:0]   wr_len = '0;
  logic         wr_lsb_first = 1'b0;
  logic [7:0]   sck_div = '0;
  logic         wr_start = 1'b0;
  logic         clr_req = 1'b0;
  logic         oe_en = 1'b0;
  logic         wr_ready, wr_done, hc595_ser, hc595_sck, hc595_rck, hc595_srclr_n, hc595_oe_n;

  hc595_chain_drive #(.MAX_BITS(256), .LEN_W(9), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_len(wr_len),
    .wr_lsb_first(wr_lsb_first), .sck_div(sck_div), .wr_start(wr_start),
    .clr_req(clr_req), .oe_en(oe_en), .wr_ready(wr_ready), .wr_done(wr_done),
    .hc595_ser(hc595_ser), .hc595_sck(hc595_sck), .hc595_rck(hc595_rck),
    .hc595_srclr_n(hc595_srclr_n), .hc595_oe_n(hc595_oe_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame model: what is in flight, when it was accepted, and when (if ever) it was aborted.
  bit           m_act = 1'b0;
  int           m_acc = 0;
  int           m_abort = 32'h7fffffff;
  int           m_kind = 0;
  int           m_h = 1;
  int           m_l = 0;
  logic [255:0] m_d = '0;
  bit           m_lsb = 1'b0;
  logic         exp_oe = 1'b1;

  always @(posedge clk) exp_oe <= rst ? 1'b1 : ~oe_en;

  int   mon_rise, mon_rck, mon_rck_c, mon_srclr_lo, mon_done, mon_done_c;
  logic prev_sck = 1'b0;
  logic mon_bits[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int done_c();
    if (m_kind == 1) return 2 * m_h + 1;
    if (m_l == 0) return 1;
    return 2 * m_h * m_l + m_h + 1;
  endfunction

  function automatic logic bit_of(input int k);
    return m_lsb ? m_d[k] : m_d[m_l - 1 - k];
  endfunction

  logic e_ser, e_sck, e_rck, e_clr, e_rdy, e_done;
  int   c, dc;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      e_ser = 1'b0; e_sck = 1'b0; e_rck = 1'b0; e_clr = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
      c  = cyc - m_acc + 1;
      dc = done_c();
      if (m_act && cyc < m_abort && c >= 1 && c <= dc) begin
        e_rdy = 1'b0;
        if (c == dc) begin
          e_done = 1'b1;
        end else if (m_kind == 1) begin
          if (c <= m_h) e_clr = 1'b0;
          else e_rck = 1'b1;
        end else if (c <= 2 * m_h * m_l) begin
          e_sck = (((c - 1) % (2 * m_h)) >= m_h);
          e_ser = bit_of((c - 1) / (2 * m_h));
        end else begin
          e_rck = 1'b1;
          e_ser = bit_of(m_l - 1);
        end
      end
      chk1("ser", hc595_ser, e_ser);
      chk1("sck", hc595_sck, e_sck);
      chk1("rck", hc595_rck, e_rck);
      chk1("srclr_n", hc595_srclr_n, e_clr);
      chk1("wr_ready", wr_ready, e_rdy);
      chk1("wr_done", wr_done, e_done);
      chk1("oe_n", hc595_oe_n, exp_oe);

      if (hc595_sck === 1'b1 && prev_sck === 1'b0) begin
        mon_rise++;
        mon_bits.push_back(hc595_ser);
      end
      prev_sck = hc595_sck;
      if (hc595_rck === 1'b1) begin
        if (mon_rck == 0) mon_rck_c = c;
        mon_rck++;
      end
      if (hc595_srclr_n === 1'b0) mon_srclr_lo++;
      if (wr_done === 1'b1) begin
        mon_done++;
        mon_done_c = c;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_rise = 0; mon_rck = 0; mon_rck_c = 0; mon_srclr_lo = 0; mon_done = 0; mon_done_c = 0;
    mon_bits.delete();
  endtask

  task automatic run(input logic [255:0] d, input int len, input bit lsb, input int div,
                     input bit clr, input bit st);
    wr_data = d; wr_len = 9'(len); wr_lsb_first = lsb; sck_div = 8'(div);
    clr_req = clr; wr_start = st;
    m_act = 1'b1; m_acc = cyc + 1; m_abort = 32'h7fffffff;
    m_kind = clr ? 1 : 0; m_h = div + 1; m_l = (len > 256) ? 256 : len;
    m_d = d; m_lsb = lsb;
    mon_clear();
    tick();
    wr_start = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wait_end(input int already);
    repeat (done_c() + 1 - already) tick();
    m_act = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    mon_clear();
    repeat (3) tick();
    chk1("reset wr_ready", wr_ready, 1'b1);
    chk1("reset sck", hc595_sck, 1'b0);
    chk1("reset srclr_n", hc595_srclr_n, 1'b1);
    chk1("reset oe_n", hc595_oe_n, 1'b1);
    rst = 1'b0;
    tick();

    // 1: MSB-first 8 bits
    run(256'h0F, 8, 1'b0, 0, 1'b0, 1'b1);
    wait_end(0);
    pat = 8'b0000_1111;
    chk_int("t1 rises", mon_rise, 8);
    for (int i = 0; i < 8 && i < mon_bits.size(); i++) chk1("t1 bit", mon_bits[i], pat[7-i]);
    chk_int("t1 rck cycles", mon_rck, 1);
    chk_int("t1 rck at", mon_rck_c, 17);
    chk_int("t1 done at", mon_done_c, 18);

    // 2: LSB-first 8 bits
    run(256'h0F, 8, 1'b1, 0, 1'b0, 1'b1);
    wait_end(0);
    pat = 8'b1111_0000;
    chk_int("t2 rises", mon_rise, 8);
    for (int i = 0; i < 8 && i < mon_bits.size(); i++) chk1("t2 bit", mon_bits[i], pat[7-i]);
    chk_int("t2 done at", mon_done_c, 18);

    // 3: slow clock, full chain, inputs disturbed mid-frame
    run({32{8'hAA}}, 256, 1'b0, 3, 1'b0, 1'b1);
    repeat (100) tick();
    sck_div = 8'd0; wr_data = '0; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    wait_end(101);
    chk_int("t3 rises", mon_rise, 256);
    chk_int("t3 rck cycles", mon_rck, 4);
    chk_int("t3 done at", mon_done_c, 2053);
    chk_int("t3 done count", mon_done, 1);
    if (mon_bits.size() == 256) begin
      chk1("t3 first bit", mon_bits[0], 1'b1);
      chk1("t3 second bit", mon_bits[1], 1'b0);
      chk1("t3 last bit", mon_bits[255], 1'b0);
    end

    // 4a: zero length
    run(256'hFF, 0, 1'b0, 2, 1'b0, 1'b1);
    wait_end(0);
    chk_int("t4a rises", mon_rise, 0);
    chk_int("t4a rck", mon_rck, 0);
    chk_int("t4a done at", mon_done_c, 1);

    // 4b: over-long length clamps to 256
    run(~256'h0, 300, 1'b1, 0, 1'b0, 1'b1);
    wait_end(0);
    chk_int("t4b rises", mon_rise, 256);
    chk_int("t4b done at", mon_done_c, 514);

    // 5: clear beats start
    run(256'hFF, 8, 1'b0, 1, 1'b1, 1'b1);
    wait_end(0);
    chk_int("t5 srclr low", mon_srclr_lo, 2);
    chk_int("t5 rck", mon_rck, 2);
    chk_int("t5 done count", mon_done, 1);
    chk_int("t5 rises", mon_rise, 0);

    // 6: reset during bit 5, then output enable
    run(256'h5A, 8, 1'b0, 0, 1'b0, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    m_abort = cyc + 1;
    tick();
    chk1("t6 sck after rst", hc595_sck, 1'b0);
    chk1("t6 ser after rst", hc595_ser, 1'b0);
    chk1("t6 ready after rst", wr_ready, 1'b1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    m_act = 1'b0;
    chk_int("t6 rises", mon_rise, 5);
    chk_int("t6 rck", mon_rck, 0);
    chk_int("t6 done", mon_done, 0);
    oe_en = 1'b1;
    @(negedge clk);
    chk1("t6 oe_n before", hc595_oe_n, 1'b1);
    tick();
    chk1("t6 oe_n after", hc595_oe_n, 1'b0);
    oe_en = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
